// File: rtl/present_msk_ctrl_if.sv
// Control bundle between the PRESENT-80 masked-core sequencer and its datapath.
// The master side is the sequencer; the slave side is the datapath and its clients.
interface present_msk_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic       rnd_valid;
    logic       rnd_req;
    logic       pipe_en;
    logic       sel_load;
    logic       en_state;
    logic       en_key;
    logic       clr_state;
    logic [4:0] round_cnt;
    logic       out_valid;
    logic       out_ready;

    modport master (
        input  in_valid, rnd_valid, out_ready,
        output in_ready, rnd_req, pipe_en, sel_load, en_state, en_key,
               clr_state, round_cnt, out_valid
    );

    modport slave (
        output in_valid, rnd_valid, out_ready,
        input  in_ready, rnd_req, pipe_en, sel_load, en_state, en_key,
               clr_state, round_cnt, out_valid
    );
endinterface

// File: rtl/present_msk_ctrl.sv
// Round sequencer for the masked PRESENT-80 core: load, 31 rounds of SBOX_LAT
// cycles each (stalling on missing randomness), then hold the result until taken.
module present_msk_ctrl #(
    parameter int d        = 2,
    parameter int SBOX_LAT = 4,
    parameter int NROUNDS  = 31
) (
    input  logic               clk,
    input  logic               rst,
    present_msk_ctrl_if.master bus
);

    localparam int              PW       = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
    localparam logic [PW-1:0]   PH_LAST  = PW'(SBOX_LAT - 1);
    localparam logic [4:0]      RC_LAST  = 5'(NROUNDS);

    if (SBOX_LAT < 1 || SBOX_LAT > 15 || NROUNDS < 1 || NROUNDS > 31 || d < 1) begin : g_param_err
        $error("present_msk_ctrl: unsupported parameter value");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [4:0]    round_q, round_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            round_q <= 5'd1;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            round_q <= round_d;
        end
    end

    // Everything is a decode of the registered state; only ROUND gates its
    // strobes with rnd_valid so a missing random word stalls that very cycle.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        round_d       = round_q;
        bus.in_ready  = 1'b0;
        bus.rnd_req   = 1'b0;
        bus.pipe_en   = 1'b0;
        bus.sel_load  = 1'b0;
        bus.en_state  = 1'b0;
        bus.en_key    = 1'b0;
        bus.clr_state = 1'b0;
        bus.out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                bus.in_ready  = 1'b1;
                bus.clr_state = 1'b1;
                round_d       = 5'd1;
                if (bus.in_valid) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bus.sel_load = 1'b1;
                bus.en_state = 1'b1;
                bus.en_key   = 1'b1;
                phase_d      = '0;
                state_d      = ROUND;
            end
            ROUND: begin
                bus.pipe_en = bus.rnd_valid;
                bus.rnd_req = bus.rnd_valid;
                if (bus.rnd_valid) begin
                    if (phase_q == PH_LAST) begin
                        bus.en_state = 1'b1;
                        bus.en_key   = 1'b1;
                        phase_d      = '0;
                        if (round_q == RC_LAST) begin
                            state_d = DONE;
                        end else begin
                            round_d = round_q + 5'd1;
                        end
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                    round_d = 5'd1;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
                round_d = 5'd1;
            end
        endcase
    end

    assign bus.round_cnt = round_q;

endmodule

// File: tb/tb_present_msk_ctrl.sv
// Bench for present_msk_ctrl: vector table, directed multi-cycle sequences and a
// randomized run, all cross-checked every cycle against a progress-count model.
module tb_present_msk_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    present_msk_ctrl_if bus4 ();
    present_msk_ctrl_if bus1 ();

    present_msk_ctrl #(.d(2), .SBOX_LAT(4), .NROUNDS(31)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    present_msk_ctrl #(.d(2), .SBOX_LAT(1), .NROUNDS(31)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // {in_ready, clr_state, sel_load, en_state, en_key, pipe_en, rnd_req, out_valid, round_cnt}
    logic [12:0] o4, o1;
    assign o4 = {bus4.in_ready, bus4.clr_state, bus4.sel_load, bus4.en_state, bus4.en_key,
                 bus4.pipe_en, bus4.rnd_req, bus4.out_valid, bus4.round_cnt};
    assign o1 = {bus1.in_ready, bus1.clr_state, bus1.sel_load, bus1.en_state, bus1.en_key,
                 bus1.pipe_en, bus1.rnd_req, bus1.out_valid, bus1.round_cnt};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: a job is just a count w of randomness-enabled cycles
    // spent in rounds; round number and update strobes follow from w / L.
    // mode: 0 idle, 1 load, 2 rounds, 3 result held.
    function automatic logic [12:0] mdl_out(input int mode, input int w, input logic rv, input int lat);
        logic en;
        case (mode)
            0: return {8'b1100_0000, 5'd1};
            1: return {8'b0011_1000, 5'd1};
            2: begin
                en = rv && ((w % lat) == lat - 1);
                return {3'b000, en, en, rv, rv, 1'b0, 5'(w / lat + 1)};
            end
            default: return {8'b0000_0001, 5'd31};
        endcase
    endfunction

    task automatic mdl_step(input int mode, input int w, input logic rs, input logic iv,
                            input logic rv, input logic ordy, input int lat,
                            output int nmode, output int nw);
        nmode = mode;
        nw    = w;
        if (!rs) begin
            nmode = 0;
            nw    = 0;
        end else begin
            case (mode)
                0: if (iv) nmode = 1;
                1: begin nmode = 2; nw = 0; end
                2: if (rv) begin
                    nw = w + 1;
                    if (nw == 31 * lat) nmode = 3;
                end
                default: if (ordy) nmode = 0;
            endcase
        end
    endtask

    int m4_mode = 0, m4_w = 0, m1_mode = 0, m1_w = 0;
    logic [12:0] e4, e1;

    always @(negedge clk) begin
        if (chk_en) begin
            e4 = mdl_out(m4_mode, m4_w, bus4.rnd_valid, 4);
            chk("model_lat4", 32'(o4), 32'(e4));
            mdl_step(m4_mode, m4_w, rst, bus4.in_valid, bus4.rnd_valid, bus4.out_ready, 4, m4_mode, m4_w);
            e1 = mdl_out(m1_mode, m1_w, bus1.rnd_valid, 1);
            chk("model_lat1", 32'(o1), 32'(e1));
            mdl_step(m1_mode, m1_w, rst, bus1.in_valid, bus1.rnd_valid, bus1.out_ready, 1, m1_mode, m1_w);
        end
    end

    typedef struct {
        logic        rst_n;
        logic        iv;
        logic        rv;
        logic        ordy;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl [12];

    // Runs one job on the SBOX_LAT=4 instance; entered and left just after a rising edge.
    task automatic job4(input int stall_rc, input int stall_len, input int bp, input bit tog,
                        output int lat, output int npulse);
        int l0, k, nst;
        bit done, st_now, st_bad, held_bad;
        lat = -1; npulse = 0; nst = 0; done = 0; st_now = 0; st_bad = 0; held_bad = 0;
        k = 0;
        while (!bus4.in_ready && k < 300) begin
            @(posedge clk); #1; k++;
        end
        bus4.out_ready = (bp == 0);
        bus4.rnd_valid = 1'b1;
        bus4.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        l0 = cyc;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (bus4.en_state) npulse++;
            if (st_now && (bus4.pipe_en || bus4.round_cnt != 5'(stall_rc))) st_bad = 1;
            if (bus4.out_valid) begin
                done = 1;
                lat  = cyc - l0 + 1;
            end else begin
                @(posedge clk); #1;
                st_now = (nst < stall_len) && (bus4.round_cnt == 5'(stall_rc));
                if (st_now) nst++;
                bus4.rnd_valid = !st_now;
                bus4.in_valid  = tog && !bus4.in_ready && ($urandom_range(0, 1) == 1);
            end
        end
        if (stall_len > 0) chk("stall_hold", 32'(st_bad), 0);
        if (bp > 0) begin
            for (int i = 0; i < bp; i++) begin
                @(posedge clk); #1;
                bus4.in_valid = 1'b0;
                @(negedge clk);
                if (!bus4.out_valid || bus4.en_state || bus4.en_key || bus4.pipe_en) held_bad = 1;
            end
            chk("bp_hold", 32'(held_bad), 0);
            @(posedge clk); #1;
            bus4.out_ready = 1'b1;
            @(negedge clk);
            chk("bp_release_ov", 32'(bus4.out_valid), 1);
        end
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        @(negedge clk);
        chk("idle_after_done", 32'({bus4.in_ready, bus4.out_valid}), 32'b10);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, np, k, ov_cnt, n, run, maxrun;
        int ovc [4];

        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, {8'b1100_0000, 5'd1}};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, {8'b1100_0000, 5'd1}};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, {8'b0011_1000, 5'd1}};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, {8'b0000_0110, 5'd1}};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, {8'b0000_0110, 5'd1}};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, {8'b0000_0000, 5'd1}};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, {8'b0000_0110, 5'd1}};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, {8'b0001_1110, 5'd1}};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, {8'b0000_0000, 5'd2}};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, {8'b0000_0110, 5'd2}};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, {8'b0000_0110, 5'd2}};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, {8'b1100_0000, 5'd1}};

        rst = 1'b0;
        bus4.in_valid = 1'b0; bus4.rnd_valid = 1'b1; bus4.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.rnd_valid = 1'b1; bus1.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;

        for (int i = 0; i < 12; i++) begin
            rst            = tbl[i].rst_n;
            bus4.in_valid  = tbl[i].iv;
            bus4.rnd_valid = tbl[i].rv;
            bus4.out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(o4), 32'(tbl[i].exp));
            @(posedge clk); #1;
        end
        rst = 1'b1;
        bus4.in_valid = 1'b0;

        job4(0, 0, 0, 1'b0, lat, np);
        chk("nominal_lat", lat, 126);
        chk("nominal_pulses", np, 32);

        job4(5, 7, 0, 1'b0, lat, np);
        chk("stall_lat", lat, 133);
        chk("stall_pulses", np, 32);

        job4(0, 0, 20, 1'b0, lat, np);
        chk("bp_lat", lat, 126);

        job4(0, 0, 0, 1'b1, lat, np);
        chk("ignored_in_lat", lat, 126);
        chk("ignored_in_pulses", np, 32);

        bus4.rnd_valid = 1'b1;
        bus4.out_ready = 1'b1;
        bus4.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        k = 0;
        while (bus4.round_cnt != 5'd17 && k < 300) begin
            @(posedge clk); #1; k++;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_job", 32'({bus4.in_ready, bus4.clr_state, bus4.out_valid, bus4.round_cnt}),
            32'({3'b110, 5'd1}));
        ov_cnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus4.out_valid) ov_cnt++;
        end
        chk("no_ov_after_rst", ov_cnt, 0);
        @(posedge clk); #1;
        job4(0, 0, 0, 1'b0, lat, np);
        chk("post_rst_lat", lat, 126);

        bus1.rnd_valid = 1'b1;
        bus1.out_ready = 1'b1;
        bus1.in_valid  = 1'b1;
        n = 0; run = 0; maxrun = 0;
        for (int i = 0; i < 4; i++) ovc[i] = 0;
        for (int i = 0; i < 400 && n < 4; i++) begin
            @(negedge clk);
            if (bus1.en_state && bus1.pipe_en) begin
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            if (bus1.out_valid) begin
                ovc[n] = cyc;
                n++;
            end
            @(posedge clk); #1;
        end
        bus1.in_valid = 1'b0;
        chk("b2b_period0", ovc[1] - ovc[0], 34);
        chk("b2b_period1", ovc[2] - ovc[1], 34);
        chk("b2b_period2", ovc[3] - ovc[2], 34);
        chk("b2b_round_run", maxrun, 31);

        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 399) != 0);
            bus4.in_valid  = ($urandom_range(0, 3) == 0);
            bus4.rnd_valid = ($urandom_range(0, 4) != 0);
            bus4.out_ready = ($urandom_range(0, 1) == 1);
            bus1.in_valid  = ($urandom_range(0, 3) == 0);
            bus1.rnd_valid = ($urandom_range(0, 4) != 0);
            bus1.out_ready = ($urandom_range(0, 1) == 1);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
